// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Owns the PC, issues credit-limited in-order imem requests and
//            buffers returned instructions in a queue with a registered head.
// Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter int                    ADDR_WIDTH  = 64,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    QUEUE_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [ADDR_WIDTH-1:0]  imem_req_addr,
  input  logic                   imem_resp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_resp_data,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0]  out_pc
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int PW = $clog2(QUEUE_DEPTH);

  localparam logic [CW-1:0]         C_CNT_ONE = CW'(1);
  localparam logic [CW:0]           C_DEPTH   = (CW + 1)'(QUEUE_DEPTH);
  localparam logic [PW-1:0]         C_PTR_ONE = PW'(1);
  localparam logic [ADDR_WIDTH-1:0] C_STEP    = ADDR_WIDTH'(4);

  // Architectural state
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [ADDR_WIDTH-1:0]  r_resp_pc;
  logic [CW-1:0]          r_inflight;
  logic [CW-1:0]          r_count;
  logic [CW-1:0]          r_drop;
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic                   r_out_valid;
  logic [INSTR_WIDTH-1:0] r_out_instr;
  logic [ADDR_WIDTH-1:0]  r_out_pc;

  logic [INSTR_WIDTH-1:0] r_q_instr [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0]  r_q_pc    [QUEUE_DEPTH];

  logic [CW:0]            w_credit_used;
  logic                   w_req_valid;
  logic                   w_req_fire;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_drop_resp;
  logic [ADDR_WIDTH-1:0]  w_redirect_pc;
  logic [CW-1:0]          w_inflight_next;
  logic [CW-1:0]          w_count_next;
  logic [PW-1:0]          w_rd_ptr_next;
  logic                   w_head_is_push;
  logic [INSTR_WIDTH-1:0] w_head_instr;
  logic [ADDR_WIDTH-1:0]  w_head_pc;
  logic                   w_unused_pc_lsbs;

  // Credits cover both outstanding responses and queued entries, so every
  // response always has a slot waiting for it.
  assign w_credit_used  = {1'b0, r_inflight} + {1'b0, r_count};
  assign w_req_valid    = !rst && !redirect_valid && (w_credit_used < C_DEPTH);
  assign w_req_fire     = w_req_valid && imem_req_ready;
  assign w_drop_resp    = imem_resp_valid && (r_drop != '0);
  assign w_push         = imem_resp_valid && (r_drop == '0) && !redirect_valid;
  assign w_pop          = r_out_valid && out_ready && !redirect_valid;
  assign w_redirect_pc  = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign w_rd_ptr_next  = w_pop ? (r_rd_ptr + C_PTR_ONE) : r_rd_ptr;
  assign w_unused_pc_lsbs = ^redirect_pc[1:0];

  always_comb begin
    w_inflight_next = r_inflight;
    case ({w_req_fire, imem_resp_valid})
      2'b10:   w_inflight_next = r_inflight + C_CNT_ONE;
      2'b01:   w_inflight_next = r_inflight - C_CNT_ONE;
      default: w_inflight_next = r_inflight;
    endcase
  end

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + C_CNT_ONE;
      2'b01:   w_count_next = r_count - C_CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  // The next head comes straight from the response when the queue would
  // otherwise be empty; that gives the single-cycle resp -> out latency.
  assign w_head_is_push = w_push && ((r_count - (w_pop ? C_CNT_ONE : '0)) == '0);

  always_comb begin
    w_head_instr = r_q_instr[w_rd_ptr_next];
    w_head_pc    = r_q_pc[w_rd_ptr_next];
    if (w_head_is_push) begin
      w_head_instr = imem_resp_data;
      w_head_pc    = r_resp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_wr_ptr] <= imem_resp_data;
      r_q_pc[r_wr_ptr]    <= r_resp_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_resp_pc   <= RESET_PC;
      r_inflight  <= '0;
      r_count     <= '0;
      r_drop      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_pc    <= '0;
    end else if (redirect_valid) begin
      r_pc        <= w_redirect_pc;
      r_resp_pc   <= w_redirect_pc;
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_pc    <= '0;
      r_inflight  <= w_inflight_next;
      // Stale responses are a subset of the outstanding ones, so after a
      // redirect everything still outstanding is stale.
      r_drop      <= w_inflight_next;
    end else begin
      if (w_req_fire) begin
        r_pc <= r_pc + C_STEP;
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + C_STEP;
        r_wr_ptr  <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_drop_resp) begin
        r_drop <= r_drop - C_CNT_ONE;
      end
      r_inflight  <= w_inflight_next;
      r_count     <= w_count_next;
      r_rd_ptr    <= w_rd_ptr_next;
      r_out_valid <= (w_count_next != '0);
      if (w_count_next != '0) begin
        r_out_instr <= w_head_instr;
        r_out_pc    <= w_head_pc;
      end else begin
        r_out_instr <= '0;
        r_out_pc    <= '0;
      end
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign out_valid      = r_out_valid;
  assign out_instr      = r_out_instr;
  assign out_pc         = r_out_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Randomized scoreboard bench for fetch_unit with a memory model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

  localparam int          AW   = 64;
  localparam int          IW   = 32;
  localparam int          QD   = 2;
  localparam logic [63:0] RPC  = 64'h0;
  localparam int          HALF = 5;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } req_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req_valid;
  logic          imem_req_ready = 1'b1;
  logic [AW-1:0] imem_req_addr;
  logic          imem_resp_valid = 1'b0;
  logic [IW-1:0] imem_resp_data = '0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;

  fetch_unit #(
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(IW),
    .RESET_PC   (RPC),
    .QUEUE_DEPTH(QD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  always #HALF clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  int          consumed = 0;
  int          accepts = 0;
  req_t        pend[$];
  logic [63:0] exp_q[$];
  logic [63:0] exp_tail = RPC;

  // Stimulus intents, applied by step() at the next falling edge
  logic        rst_req = 1'b1;
  logic        redir_req = 1'b0;
  logic [63:0] redir_pc_req = '0;
  logic        or_req = 1'b1;
  logic        or_rand = 1'b0;
  logic        rdy_rand = 1'b0;
  int          lat_min = 1;
  int          lat_max = 1;
  logic        want_first = 1'b0;
  logic [63:0] first_exp = '0;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ {a[63:34], 2'b01} ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Program order restarts at the target; decode must see it contiguously.
  task automatic restart(input logic [63:0] target);
    exp_q.delete();
    exp_tail = target;
  endtask

  task automatic step();
    logic was_rst;
    int   lat;
    @(negedge clk);
    was_rst        = rst;
    rst            = rst_req;
    redirect_valid = redir_req && !rst_req;
    redirect_pc    = redir_pc_req;
    redir_req      = 1'b0;
    out_ready      = or_rand ? ($urandom_range(0, 3) != 0) : or_req;
    imem_req_ready = rdy_rand ? ($urandom_range(0, 1) != 0) : 1'b1;
    if (rst) begin
      pend.delete();
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      restart(RPC);
    end else begin
      if (redirect_valid) restart({redirect_pc[AW-1:2], 2'b00});
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = instr_of(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
      end
    end
    while (exp_q.size() < 32) begin
      exp_q.push_back(exp_tail);
      exp_tail = exp_tail + 64'd4;
    end
    #1;
    if (rst && !was_rst) begin
      check(out_valid === 1'b0, "rst_async_out_valid", 64'(out_valid), 64'd0);
      check(imem_req_valid === 1'b0, "rst_async_req_valid", 64'(imem_req_valid), 64'd0);
    end
    #(HALF - 2);
    if (!rst && imem_req_valid && imem_req_ready) begin
      lat = int'($urandom_range(lat_min, lat_max));
      pend.push_back('{imem_req_addr, cyc + lat});
      accepts++;
      if (want_first) begin
        check(imem_req_addr === first_exp, "first_fetch_addr", imem_req_addr, first_exp);
        want_first = 1'b0;
      end
    end
    if (!rst) check(pend.size() <= QD, "outstanding_le_depth", 64'(pend.size()), 64'(QD));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_consumed(input int n, input int budget, input string name);
    int start;
    int k;
    start = consumed;
    k = 0;
    while ((consumed - start) < n && k < budget) begin
      step();
      k++;
    end
    check((consumed - start) >= n, name, 64'(consumed - start), 64'(n));
  endtask

  // Monitor: pops the scoreboard on every accepted head
  initial begin : monitor
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #(HALF - 1);
      if (!rst) begin
        if (redirect_valid)
          check(imem_req_valid === 1'b0, "redirect_blocks_req", 64'(imem_req_valid), 64'd0);
        if (out_valid && out_ready && !redirect_valid) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "stream_unexpected_output", out_pc, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check(out_pc === e, "stream_pc", out_pc, e);
            check(out_instr === instr_of(e), "stream_instr", 64'(out_instr), 64'(instr_of(e)));
          end
          consumed++;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int start;
    int k;
    run(3);
    check(out_valid === 1'b0, "reset_out_valid", 64'(out_valid), 64'd0);
    check(out_pc === '0, "reset_out_pc", out_pc, 64'd0);
    check(out_instr === '0, "reset_out_instr", 64'(out_instr), 64'd0);
    check(imem_req_valid === 1'b0, "reset_req_valid", 64'(imem_req_valid), 64'd0);

    // Sequential fetch, latency 1, decode always ready
    rst_req    = 1'b0;
    want_first = 1'b1;
    first_exp  = RPC;
    wait_consumed(20, 80, "t1_progress");
    start = consumed;
    run(30);
    check((consumed - start) >= 15, "t1_throughput", 64'(consumed - start), 64'd15);

    // Decode stalled: requests limited to the queue depth
    rst_req = 1'b1;
    run(2);
    rst_req = 1'b0;
    or_req  = 1'b0;
    accepts = 0;
    run(10);
    check(accepts == QD, "t2_req_count", 64'(accepts), 64'(QD));
    check(imem_req_valid === 1'b0, "t2_req_stalled", 64'(imem_req_valid), 64'd0);
    or_req = 1'b1;
    wait_consumed(10, 60, "t2_resume");

    // Latency 3, redirect with two requests outstanding
    lat_min = 3;
    lat_max = 3;
    k = 0;
    while (pend.size() < 2 && k < 20) begin
      step();
      k++;
    end
    check(pend.size() == 2, "t3_two_in_flight", 64'(pend.size()), 64'd2);
    redir_req    = 1'b1;
    redir_pc_req = 64'h100;
    wait_consumed(2, 40, "t3_after_redirect");

    // Back-to-back redirects
    run(3);
    redir_req    = 1'b1;
    redir_pc_req = 64'h400;
    step();
    redir_req    = 1'b1;
    redir_pc_req = 64'h800;
    wait_consumed(3, 40, "bb_redirect");

    // Unaligned redirect target
    want_first   = 1'b1;
    first_exp    = 64'h200;
    redir_req    = 1'b1;
    redir_pc_req = 64'h203;
    wait_consumed(2, 40, "t4_after_redirect");

    // PC wrap at the top of the address space
    lat_min      = 1;
    lat_max      = 1;
    want_first   = 1'b1;
    first_exp    = 64'hFFFF_FFFF_FFFF_FFFC;
    redir_req    = 1'b1;
    redir_pc_req = 64'hFFFF_FFFF_FFFF_FFFC;
    wait_consumed(4, 40, "t5_wrap");

    // Reset with a full queue
    or_req = 1'b0;
    run(8);
    check(out_valid === 1'b1, "t6_queue_filled", 64'(out_valid), 64'd1);
    rst_req = 1'b1;
    run(2);
    rst_req    = 1'b0;
    or_req     = 1'b1;
    want_first = 1'b1;
    first_exp  = RPC;
    wait_consumed(3, 40, "t6_restart");

    // Randomized traffic
    rdy_rand = 1'b1;
    or_rand  = 1'b1;
    lat_min  = 1;
    lat_max  = 4;
    start    = consumed;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
      end else begin
        if ($urandom_range(0, 19) == 0) begin
          redir_req = 1'b1;
          if ($urandom_range(0, 3) == 0)
            redir_pc_req = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
          else
            redir_pc_req = {$urandom(), $urandom()};
        end
        step();
      end
    end
    check((consumed - start) >= 150, "random_progress", 64'(consumed - start), 64'd150);

    rdy_rand = 1'b0;
    or_rand  = 1'b0;
    run(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
